// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and helpers for the multi-channel tick generator.
//   CLK_HZ     - system clock frequency (clk_50mhz)
//   CNT_W_DEF  - default counter / divide-ratio width (reaches 1 Hz at 50 MHz)
//   DIV_100HZ  - divide ratio giving a 100 Hz square wave
//   DIV_1KHZ   - divide ratio giving a 1 kHz square wave
//   hz_to_div  - square-wave frequency to divide ratio (tick runs at 2*hz)
package tick_gen_pkg;

  localparam int CLK_HZ    = 50_000_000;
  localparam int CNT_W_DEF = 26;
  localparam int DIV_100HZ = 250_000;
  localparam int DIV_1KHZ  = 25_000;

  // sq_out toggles once per tick, so one square-wave period spans two ticks.
  function automatic int hz_to_div(input int hz);
    int div_v;
    if (hz <= 32'sd0) begin
      div_v = 32'sd0;
    end else begin
      div_v = CLK_HZ / (32'sd2 * hz);
    end
    return div_v;
  endfunction

endpackage

// File: rtl/multi_tick_gen_channel.sv
// tick_gen_channel: one divider channel of multi_tick_gen.
// Holds the counter, the active divide ratio, a shadow ratio with its pending
// flag, and the registered tick / square-wave outputs.
// Ports:
//   clk_50mhz, rst_50mhz - clock and asynchronous active-high reset
//   en                   - run enable (counter and sq_out hold when low)
//   sync_clr             - synchronous phase clear, applies a pending ratio
//   load_we              - accepted load targeting this channel
//   load_div             - ratio written into the shadow register
//   pending              - shadow ratio waiting to be applied
//   tick                 - one-cycle strobe per period
//   sq_out               - square wave toggling on every tick
// Build option: MULTI_TICK_GEN_SQ_EN builds the square-wave flop; without it
// sq_out is tied to 0.
module tick_gen_channel #(
  parameter int CNT_W    = 26,
  parameter int DIV_INIT = 25_000
) (
  input  logic             clk_50mhz,
  input  logic             rst_50mhz,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             load_we,
  input  logic [CNT_W-1:0] load_div,
  output logic             pending,
  output logic             tick,
  output logic             sq_out
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] shadow_r;
  logic             pending_r;
  logic             tick_r;
  logic [CNT_W-1:0] eff_div_s;
  logic             wrap_s;

  // Effective ratio (0 behaves as 1) and wrap detect for the current cycle.
  always_comb begin
    eff_div_s = div_r;
    if (div_r == ZERO) begin
      eff_div_s = ONE;
    end else begin
      eff_div_s = div_r;
    end
    // >= keeps the counter bounded even if a disabled-apply shrank the ratio
    // below a held count.
    wrap_s = en && (cnt_r >= (eff_div_s - ONE));
  end

  // Counter and tick strobe; sync_clr outranks enable and wrap.
  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      cnt_r  <= ZERO;
      tick_r <= 1'b0;
    end else if (sync_clr) begin
      cnt_r  <= ZERO;
      tick_r <= 1'b0;
    end else if (!en) begin
      cnt_r  <= cnt_r;
      tick_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= ZERO;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + ONE;
      tick_r <= 1'b0;
    end
  end

  // Shadow/active ratio: a pending ratio lands only at wrap, on sync_clr, or
  // while the channel is stopped, so a running period never gets cut short.
  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      div_r     <= DIV_RST;
      shadow_r  <= DIV_RST;
      pending_r <= 1'b0;
    end else if (load_we) begin
      // Loads are only accepted while nothing is pending, so this never
      // collides with an apply; a load in a wrap cycle waits for the next wrap.
      shadow_r  <= load_div;
      pending_r <= 1'b1;
    end else if (pending_r && (sync_clr || !en || wrap_s)) begin
      div_r     <= shadow_r;
      pending_r <= 1'b0;
    end else begin
      div_r     <= div_r;
      pending_r <= pending_r;
    end
  end

`ifdef MULTI_TICK_GEN_SQ_EN
  logic sq_r;

  // Square wave: toggles on each wrap, holds while disabled.
  always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
    if (rst_50mhz) begin
      sq_r <= 1'b0;
    end else if (sync_clr) begin
      sq_r <= 1'b0;
    end else if (wrap_s) begin
      sq_r <= ~sq_r;
    end else begin
      sq_r <= sq_r;
    end
  end

  assign sq_out = sq_r;
`else
  assign sq_out = 1'b0;
`endif

  assign pending = pending_r;
  assign tick    = tick_r;

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent programmable dividers from clk_50mhz.
// Each channel yields a one-cycle tick (clock enable) and a 50 % square wave.
// Ports:
//   clk_50mhz, rst_50mhz - 50 MHz clock, asynchronous active-high reset
//   ch_en      - per-channel run enable
//   sync_clr   - synchronous clear of every channel phase
//   load_valid / load_ready / load_ch / load_div - ratio reload handshake;
//                load_ready is combinational on load_ch, loads to a channel
//                index >= NUM_CH are accepted and dropped
//   tick       - per-channel one-cycle strobe
//   sq_out     - per-channel square wave
// Build option: define MULTI_TICK_GEN_SQ_EN to build the sq_out flops;
// otherwise sq_out is constant 0.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_INIT0 = DIV_100HZ,
  parameter int DIV_INIT1 = DIV_1KHZ
) (
  input  logic                                       clk_50mhz,
  input  logic                                       rst_50mhz,
  input  logic [NUM_CH-1:0]                          ch_en,
  input  logic                                       sync_clr,
  input  logic                                       load_valid,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] load_ch,
  input  logic [CNT_W-1:0]                           load_div,
  output logic                                       load_ready,
  output logic [NUM_CH-1:0]                          tick,
  output logic [NUM_CH-1:0]                          sq_out
);

  localparam int LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD_W = 1 << LCH_W;

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] load_we_s;
  logic [PAD_W-1:0]  pend_pad_s;
  logic              accept_s;

  // Ready reflects the addressed channel's pending flag; unused indices read
  // as never pending so out-of-range loads are accepted.
  always_comb begin
    pend_pad_s               = '0;
    pend_pad_s[NUM_CH-1:0]   = pending_s;
    if (pend_pad_s[load_ch]) begin
      load_ready = 1'b0;
    end else begin
      load_ready = 1'b1;
    end
    accept_s = load_valid && load_ready;
  end

  // Decode the accepted load into one write strobe per channel.
  always_comb begin
    load_we_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s && (int'(load_ch) == i)) begin
        load_we_s[i] = 1'b1;
      end else begin
        load_we_s[i] = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen_channel #(
      .CNT_W    (CNT_W),
      .DIV_INIT ((i == 0) ? DIV_INIT0 : DIV_INIT1)
    ) u_ch (
      .clk_50mhz (clk_50mhz),
      .rst_50mhz (rst_50mhz),
      .en        (ch_en[i]),
      .sync_clr  (sync_clr),
      .load_we   (load_we_s[i]),
      .load_div  (load_div),
      .pending   (pending_s[i]),
      .tick      (tick[i]),
      .sq_out    (sq_out[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen (three channels so that a 2-bit load_ch
// can address an out-of-range index). Square-wave expectations follow the
// MULTI_TICK_GEN_SQ_EN build option.
module tb_multi_tick_gen;
  import tick_gen_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 26;
`ifdef MULTI_TICK_GEN_SQ_EN
  localparam logic SQ = 1'b1;
`else
  localparam logic SQ = 1'b0;
`endif

  logic           clk_50mhz = 1'b0;
  logic           rst_50mhz;
  logic [NCH-1:0] ch_en;
  logic           sync_clr;
  logic           load_valid;
  logic [1:0]     load_ch;
  logic [CW-1:0]  load_div;
  logic           load_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq_out;

  int n_tests = 0;
  int n_fail  = 0;

  multi_tick_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_50mhz  (rst_50mhz),
    .ch_en      (ch_en),
    .sync_clr   (sync_clr),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .tick       (tick),
    .sq_out     (sq_out)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic test_reset();
    rst_50mhz = 1'b1; ch_en = 3'b111; sync_clr = 1'b0;
    load_valid = 1'b0; load_ch = 2'd0; load_div = 26'd0;
    step(); step();
    n_tests++; if (tick !== 3'b000) begin n_fail++; $display("FAIL reset_tick: got %b expected 000", tick); end
    n_tests++; if (sq_out !== 3'b000) begin n_fail++; $display("FAIL reset_sq: got %b expected 000", sq_out); end
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
    n_tests++; if (hz_to_div(100) !== 250000) begin n_fail++; $display("FAIL hz_to_div_100: got %0d expected 250000", hz_to_div(100)); end
    rst_50mhz = 1'b0;
  endtask

  // First ch1 period keeps 25000 despite a reload to 10 issued at cnt=100.
  task automatic test_reload();
    int n;
    int m;
    n = 0;
    repeat (100) begin step(); n++; end
    load_valid = 1'b1; load_ch = 2'd1; load_div = 26'd10; #1;
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reload_ready_pre: got %b expected 1", load_ready); end
    step(); n++;
    load_valid = 1'b0; #1;
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reload_ready_pending: got %b expected 0", load_ready); end
    while (tick[1] !== 1'b1 && n < 25100) begin step(); n++; end
    n_tests++; if (n !== 25000) begin n_fail++; $display("FAIL first_tick_ch1: got clock %0d expected 25000", n); end
    n_tests++; if (tick !== 3'b110) begin n_fail++; $display("FAIL first_tick_vec: got %b expected 110", tick); end
    n_tests++; if (sq_out[1] !== SQ) begin n_fail++; $display("FAIL first_sq_ch1: got %b expected %b", sq_out[1], SQ); end
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reload_ready_post: got %b expected 1", load_ready); end
    for (int k = 0; k < 2; k++) begin
      m = 0;
      do begin step(); m++; end while (tick[1] !== 1'b1 && m < 50);
      n_tests++; if (m !== 10) begin n_fail++; $display("FAIL reload_period_%0d: got %0d expected 10", k, m); end
    end
  endtask

  // ch0 reloaded to 20 while stopped, then paused at cnt=7 for 50 clocks.
  task automatic test_enable_gating();
    int m;
    logic seen;
    ch_en = 3'b110;
    load_valid = 1'b1; load_ch = 2'd0; load_div = 26'd20;
    step();
    load_valid = 1'b0;
    step(); #1;
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL gate_apply_disabled: got ready %b expected 1", load_ready); end
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    ch_en = 3'b111;
    m = 0;
    do begin step(); m++; end while (tick[0] !== 1'b1 && m < 40);
    n_tests++; if (m !== 20) begin n_fail++; $display("FAIL gate_first_period: got %0d expected 20", m); end
    repeat (7) step();
    ch_en = 3'b110;
    seen = 1'b0;
    repeat (50) begin step(); if (tick[0] === 1'b1) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL gate_no_tick: got tick seen %b expected 0", seen); end
    n_tests++; if (sq_out[0] !== SQ) begin n_fail++; $display("FAIL gate_sq_held: got %b expected %b", sq_out[0], SQ); end
    ch_en = 3'b111;
    m = 0;
    do begin step(); m++; end while (tick[0] !== 1'b1 && m < 40);
    n_tests++; if (m !== 13) begin n_fail++; $display("FAIL gate_resume: got %0d expected 13", m); end
  endtask

  // sync_clr lands in ch1's wrap cycle while ratio 6 is pending.
  task automatic test_resync();
    int m;
    m = 0;
    while (tick[1] !== 1'b1 && m < 20) begin step(); m++; end
    load_valid = 1'b1; load_ch = 2'd1; load_div = 26'd6;
    step();
    load_valid = 1'b0; #1;
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL resync_pending: got ready %b expected 0", load_ready); end
    repeat (8) step();
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    n_tests++; if (tick !== 3'b000) begin n_fail++; $display("FAIL resync_tick: got %b expected 000", tick); end
    n_tests++; if (sq_out !== 3'b000) begin n_fail++; $display("FAIL resync_sq: got %b expected 000", sq_out); end
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL resync_applied: got ready %b expected 1", load_ready); end
    for (int k = 0; k < 2; k++) begin
      m = 0;
      do begin step(); m++; end while (tick[1] !== 1'b1 && m < 20);
      n_tests++; if (m !== 6) begin n_fail++; $display("FAIL resync_period_%0d: got %0d expected 6", k, m); end
    end
  endtask

  // ch0 div=0, ch1 div=1, then an out-of-range load to index 3.
  task automatic test_corner();
    logic [1:0] exp_sq;
    load_valid = 1'b1; load_ch = 2'd0; load_div = 26'd0;
    step();
    load_ch = 2'd1; load_div = 26'd1;
    step();
    load_valid = 1'b0;
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    exp_sq = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_sq = ~exp_sq;
      n_tests++; if (tick[1:0] !== 2'b11) begin n_fail++; $display("FAIL corner_tick_%0d: got %b expected 11", k, tick[1:0]); end
      n_tests++; if (sq_out[1:0] !== (exp_sq & {2{SQ}})) begin n_fail++; $display("FAIL corner_sq_%0d: got %b expected %b", k, sq_out[1:0], exp_sq & {2{SQ}}); end
    end
    load_valid = 1'b1; load_ch = 2'd3; load_div = 26'd5; #1;
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", load_ready); end
    step();
    load_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      load_ch = 2'(c); #1;
      n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL oor_no_pending_ch%0d: got %b expected 1", c, load_ready); end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++; if (tick[1:0] !== 2'b11) begin n_fail++; $display("FAIL oor_tick_%0d: got %b expected 11", k, tick[1:0]); end
    end
  endtask

  // Reset mid-period restores the default ratios and restarts the phase.
  task automatic test_reset_mid();
    int n;
    rst_50mhz = 1'b1; #5;
    n_tests++; if (tick !== 3'b000 || sq_out !== 3'b000) begin n_fail++; $display("FAIL midreset_clear: got tick %b sq %b expected 000/000", tick, sq_out); end
    step();
    rst_50mhz = 1'b0; load_ch = 2'd1;
    n = 0;
    do begin step(); n++; end while (tick[1] !== 1'b1 && n < 25100);
    n_tests++; if (n !== 25000) begin n_fail++; $display("FAIL midreset_tick: got clock %0d expected 25000", n); end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_enable_gating();
    test_resync();
    test_corner();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
